fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the pipelined datapath. It tracks
//  destination registers of the instructions in EX, MEM and WB in its own shadow pipeline.
//  Each cycle it produces forwarding selects and muxed operands A and B for the ALU in EX,
//  stalls ID for one cycle on a load-use hazard, and counts stall cycles.
// PARAMETERS
//  DATA_W    16  operand / forwarded data width
//  REG_AW     4  register address width (2**REG_AW architectural regs)
//  ZERO_REG   1  1 = register 0 is hardwired zero; never matches for forwarding or stall
//  CNT_W     16  width of the stall performance counter
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous, active-high reset
//  id_valid      in   1        valid instruction in ID
//  id_rs         in   REG_AW   ID source A register
//  id_rt         in   REG_AW   ID source B register
//  id_uses_rt    in   1        ID instruction reads rt (0 = immediate form)
//  id_rd         in   REG_AW   ID destination register
//  id_wen        in   1        ID instruction writes id_rd
//  id_is_load    in   1        ID instruction is a load
//  ext_hold      in   1        global freeze (memory wait); shadow pipe holds
//  flush         in   1        branch taken; ID instruction discarded
//  ex_opa_rf     in   DATA_W   operand A from ID/EX latch
//  ex_opb_rf     in   DATA_W   operand B from ID/EX latch
//  alu_fwd_data  in   DATA_W   EX/MEM latch ALU result
//  mem_fwd_data  in   DATA_W   MEM/WB writeback data
//  src_a         out  DATA_W   ALU operand A
//  src_b         out  DATA_W   ALU operand B
//  fwd_sel_a     out  2        00 = rf, 10 = EX/MEM, 01 = MEM/WB
//  fwd_sel_b     out  2        same encoding, for operand B
//  stall_id      out  1        hold PC and IF/ID; insert bubble into EX
//  stall_cnt     out  CNT_W    saturating count of cycles with stall_id=1
// BEHAVIOUR
//  Shadow stages
//   - EX, MEM and WB each hold {v, rs, rt, uses_rt, rd, wen, load}.
//   - Reset clears every stage to a bubble (v=0) and stall_cnt to 0.
//   - Outputs at reset: stall_id=0, fwd_sel_a/b=00, src_a/b = ex_opa_rf/ex_opb_rf.
//  Advance on each rising edge when ext_hold=0:
//   - WB <= MEM; MEM <= EX.
//   - EX <= bubble if stall_id, flush or !id_valid; otherwise EX <= ID fields.
//  ext_hold=1: all stages and stall_cnt hold. Outputs keep being evaluated combinationally.
//  Match rule, ematch(s, r): s.v && s.wen && s.rd==r && !(ZERO_REG && r==0).
//  Forwarding (combinational, 0-cycle latency, on the EX stage):
//   - A: ematch(MEM, EX.rs) -> 10; else ematch(WB, EX.rs) -> 01; else 00.
//   - B: same as A using EX.rt; forced to 00 when EX.uses_rt=0.
//   - MEM beats WB when both match (newest value wins).
//   - Encoding 11 is never produced.
//   - src_x = (sel==10) ? alu_fwd_data : (sel==01) ? mem_fwd_data : ex_opx_rf.
//   - EX bubble (v=0) -> both selects 00.
//  Load-use (combinational):
//   - stall_id = id_valid && !flush && EX.load && (ematch(EX, id_rs) || (id_uses_rt && ematch(EX, id_rt))).
//   - Lasts exactly one cycle per hazard: next cycle EX holds a bubble and the load is in MEM.
//   - The dependent instruction later forwards from WB via 01.
//   - stall_id can be 1 during ext_hold. The counter does not increment while held.
//  Flush and stall in the same cycle: flush wins, so stall_id=0 and EX gets a bubble.
//  A load in MEM never forwards via 10; this is guaranteed by the stall.
//  stall_cnt increments when stall_id && !ext_hold and saturates at all-ones.
//  Reset mid-operation clears all in-flight hazards immediately; no stall is pending after reset.
// TESTING
//  1. Reset: rst=1 mid-stream -> stall_id=0, sels=00, stall_cnt=0, and EX/MEM/WB are bubbles.
//  2. Back-to-back ALU: add r3 then sub r5,r3,r4 -> EX cycle of sub: fwd_sel_a=10,
//     src_a=alu_fwd_data=16'h1234, no stall.
//  3. Distance two: add r3 / nop / or r6,r3,r3 -> fwd_sel_a=fwd_sel_b=01, src=mem_fwd_data;
//     add r3 twice then use r3 -> 10 (MEM priority).
//  4. Load-use: lw r2 then add r7,r2,r1 -> stall_id=1 for exactly 1 cycle, stall_cnt 0->1,
//     EX bubble, then fwd_sel_a=01.
//  5. Zero reg and immediate: write r0 then read r0 -> sel 00; lw r2 then addi r4,r1 with
//     id_rt=2, id_uses_rt=0 -> no stall.
//  6. Hold/flush/saturation: ext_hold=1 for 3 cycles -> stages frozen, counter frozen;
//     flush during hazard -> stall_id=0; preload counter near max -> stays at 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding and load-use stall detection
// driven by a shadow copy of the EX/MEM/WB destination-register pipeline.
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              ext_hold,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_opa_rf,
    input  logic [DATA_W-1:0] ex_opb_rf,
    input  logic [DATA_W-1:0] alu_fwd_data,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic [DATA_W-1:0] src_a,
    output logic [DATA_W-1:0] src_b,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_id,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rt;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } ex_t;
    // Past EX only the destination matters, so MEM and WB keep just that part.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wen;
    } dst_t;

    ex_t  ex;
    dst_t mem, wb;

    function automatic logic ematch(input logic v, input logic wen,
                                    input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
        return v && wen && rd == r && !(ZERO_REG != 0 && r == '0);
    endfunction

    always_comb begin
        fwd_sel_a = !ex.v ? 2'b00 :
                    ematch(mem.v, mem.wen, mem.rd, ex.rs) ? 2'b10 :
                    ematch(wb.v, wb.wen, wb.rd, ex.rs) ? 2'b01 : 2'b00;
        fwd_sel_b = (!ex.v || !ex.uses_rt) ? 2'b00 :
                    ematch(mem.v, mem.wen, mem.rd, ex.rt) ? 2'b10 :
                    ematch(wb.v, wb.wen, wb.rd, ex.rt) ? 2'b01 : 2'b00;
        src_a = fwd_sel_a == 2'b10 ? alu_fwd_data : fwd_sel_a == 2'b01 ? mem_fwd_data : ex_opa_rf;
        src_b = fwd_sel_b == 2'b10 ? alu_fwd_data : fwd_sel_b == 2'b01 ? mem_fwd_data : ex_opb_rf;
        stall_id = id_valid && !flush && ex.load &&
                   (ematch(ex.v, ex.wen, ex.rd, id_rs) ||
                    (id_uses_rt && ematch(ex.v, ex.wen, ex.rd, id_rt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex        <= '0;
            mem       <= '0;
            wb        <= '0;
            stall_cnt <= '0;
        end else if (!ext_hold) begin
            wb  <= mem;
            mem <= dst_t'{ex.v, ex.rd, ex.wen};
            ex  <= (stall_id || flush || !id_valid) ? '0 :
                   ex_t'{1'b1, id_rs, id_rt, id_uses_rt, id_rd, id_wen, id_is_load};
            if (stall_id && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks of forwarding, load-use stall
// and stall counter against an instruction-history model.
module tb_fwd_hazard_unit;
    logic        clk = 0, rst = 1;
    logic        id_valid = 0, id_uses_rt = 0, id_wen = 0, id_is_load = 0;
    logic [3:0]  id_rs = 0, id_rt = 0, id_rd = 0;
    logic        ext_hold = 0, flush = 0;
    logic [15:0] ex_opa_rf = 0, ex_opb_rf = 0, alu_fwd_data = 0, mem_fwd_data = 0;
    logic [15:0] src_a, src_b, stall_cnt;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_id;
    logic [15:0] s_src_a, s_src_b;
    logic [1:0]  s_sel_a, s_sel_b;
    logic        s_stall;
    logic [2:0]  s_cnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ext_hold(ext_hold), .flush(flush), .ex_opa_rf(ex_opa_rf), .ex_opb_rf(ex_opb_rf),
        .alu_fwd_data(alu_fwd_data), .mem_fwd_data(mem_fwd_data), .src_a(src_a), .src_b(src_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_id(stall_id), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    fwd_hazard_unit #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ext_hold(ext_hold), .flush(flush), .ex_opa_rf(ex_opa_rf), .ex_opb_rf(ex_opb_rf),
        .alu_fwd_data(alu_fwd_data), .mem_fwd_data(mem_fwd_data), .src_a(s_src_a), .src_b(s_src_b),
        .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b), .stall_id(s_stall), .stall_cnt(s_cnt)
    );

    typedef struct {
        bit v; int rs; int rt; bit ut; int rd; bit wen; bit ld;
    } ins_t;

    ins_t hist[3];   // 0 = instruction in EX, 1 = one older, 2 = two older
    int   cnt, cnt_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
        cnt = 0;
        cnt_s = 0;
    endfunction

    // Nearest older writer of r wins; distance 1 -> EX/MEM, distance 2 -> MEM/WB.
    function automatic logic [1:0] exp_sel(input int r, input bit used);
        if (!hist[0].v || !used || r == 0) return 2'b00;
        for (int k = 1; k < 3; k++)
            if (hist[k].v && hist[k].wen && hist[k].rd == r) return k == 1 ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_stall();
        ins_t e = hist[0];
        if (!id_valid || flush || !e.v || !e.ld || !e.wen || e.rd == 0) return 0;
        return e.rd == int'(id_rs) || (id_uses_rt && e.rd == int'(id_rt));
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] rf);
        return s == 2'b10 ? alu_fwd_data : s == 2'b01 ? mem_fwd_data : rf;
    endfunction

    task automatic set_id(input bit v, input int rs, input int rt, input bit ut,
                          input int rd, input bit wen, input bit ld);
        id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_uses_rt = ut;
        id_rd = 4'(rd); id_wen = wen; id_is_load = ld;
    endtask

    // Called just after a negedge with inputs set; checks, clocks, advances the model.
    task automatic cycle();
        logic [1:0] sa, sb;
        bit st;
        #1;
        sa = exp_sel(hist[0].rs, 1);
        sb = exp_sel(hist[0].rt, hist[0].ut);
        st = exp_stall();
        check("stall_id", stall_id, st);
        check("fwd_sel_a", fwd_sel_a, sa);
        check("fwd_sel_b", fwd_sel_b, sb);
        check("src_a", src_a, pick(sa, ex_opa_rf));
        check("src_b", src_b, pick(sb, ex_opb_rf));
        check("stall_cnt", stall_cnt, cnt);
        check("stall_cnt_sat", s_cnt, cnt_s);
        @(posedge clk);
        if (rst) model_reset();
        else if (!ext_hold) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (st || flush || !id_valid) ? '{default: 0} :
                      '{1, id_rs, id_rt, id_uses_rt, id_rd, id_wen, id_is_load};
            if (st && cnt < 65535) cnt++;
            if (st && cnt_s < 7) cnt_s++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        check("rst_stall", stall_id, 0);
        check("rst_sel_a", fwd_sel_a, 0);
        check("rst_cnt", stall_cnt, 0);
        cycle();
        rst = 0;
    endtask

    initial begin
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // back-to-back ALU: add r3 ; sub r5,r3,r4
        set_id(1, 1, 2, 1, 3, 1, 0); cycle();
        set_id(1, 3, 4, 1, 5, 1, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0);
        alu_fwd_data = 16'h1234; mem_fwd_data = 16'h5678; ex_opa_rf = 16'h0bad;
        #1;
        check("b2b_sel_a", fwd_sel_a, 2'b10);
        check("b2b_src_a", src_a, 16'h1234);
        check("b2b_stall", stall_id, 0);
        cycle();

        // distance two: add r3 ; nop ; or r6,r3,r3
        set_id(1, 1, 2, 1, 3, 1, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0); cycle();
        set_id(1, 3, 3, 1, 6, 1, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0); #1;
        check("d2_sel_a", fwd_sel_a, 2'b01);
        check("d2_sel_b", fwd_sel_b, 2'b01);
        check("d2_src_b", src_b, 16'h5678);
        cycle();

        // two writers of r3, newest wins
        set_id(1, 1, 2, 1, 3, 1, 0); cycle();
        set_id(1, 2, 1, 1, 3, 1, 0); cycle();
        set_id(1, 3, 0, 0, 8, 1, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0); #1;
        check("prio_sel_a", fwd_sel_a, 2'b10);
        check("prio_sel_b_imm", fwd_sel_b, 2'b00);
        cycle();

        // load-use: lw r2 ; add r7,r2,r1
        set_id(1, 1, 0, 0, 2, 1, 1); cycle();
        set_id(1, 2, 1, 1, 7, 1, 0); #1;
        check("lu_stall", stall_id, 1);
        check("lu_cnt0", stall_cnt, 0);
        cycle();
        #1;
        check("lu_stall_once", stall_id, 0);
        check("lu_bubble_sel", fwd_sel_a, 2'b00);
        check("lu_cnt1", stall_cnt, 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0); #1;
        check("lu_wb_fwd", fwd_sel_a, 2'b01);
        cycle();

        // r0 never forwards; immediate form ignores rt
        set_id(1, 1, 1, 1, 0, 1, 0); cycle();
        set_id(1, 0, 0, 1, 9, 1, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0); #1;
        check("r0_sel_a", fwd_sel_a, 2'b00);
        check("r0_sel_b", fwd_sel_b, 2'b00);
        cycle();
        set_id(1, 1, 0, 0, 2, 1, 1); cycle();
        set_id(1, 1, 2, 0, 4, 1, 0); #1;
        check("imm_no_stall", stall_id, 0);
        cycle();

        // hold with a pending hazard: stall visible, counter frozen
        set_id(1, 1, 0, 0, 2, 1, 1); cycle();
        set_id(1, 2, 1, 1, 7, 1, 0);
        ext_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", stall_id, 1);
            cycle();
        end
        check("hold_cnt", stall_cnt, cnt);
        ext_hold = 0;
        cycle();

        // flush beats stall
        set_id(1, 1, 0, 0, 2, 1, 1); cycle();
        set_id(1, 2, 1, 1, 7, 1, 0); flush = 1; #1;
        check("flush_stall", stall_id, 0);
        cycle();
        flush = 0;

        // saturate the narrow counter
        for (int i = 0; i < 10; i++) begin
            set_id(1, 1, 0, 0, 2, 1, 1); cycle();
            set_id(1, 2, 1, 1, 7, 1, 0); cycle();
        end
        check("sat_cnt", s_cnt, 3'd7);

        // mid-stream reset clears in-flight hazard
        set_id(1, 1, 0, 0, 2, 1, 1); cycle();
        set_id(1, 2, 1, 1, 7, 1, 0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 3),
                   $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            ext_hold = $urandom_range(0, 99) < 15;
            flush = $urandom_range(0, 99) < 10;
            rst = $urandom_range(0, 199) == 0;
            if (rst) model_reset();
            ex_opa_rf = 16'($urandom); ex_opb_rf = 16'($urandom);
            alu_fwd_data = 16'($urandom); mem_fwd_data = 16'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
